// File: rtl/kyber_ntt_butterfly.sv
// Pipelined Kyber NTT butterfly: CT forward always; GS inverse only when KYBER_BF_INTT_EN is defined.
// The twiddle ROM is external and synchronous (addressed with in_k, data one cycle later).
module kyber_ntt_butterfly #(
  parameter int Q = 3329,
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [6:0]   in_k,
  input  logic         in_inv,
  output logic [6:0]   zeta_ad,
  output logic         zeta_ce,
  input  logic [W-1:0] zeta_dout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b
);

  localparam logic [W:0]     Q_W1  = (W+1)'(Q);
  localparam logic [2*W-1:0] Q_W2  = (2*W)'(Q);
  localparam logic [3*W:0]   BAR_M = (3*W+1)'((64'd1 << (2*W)) / Q);

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q_W1) s = s - Q_W1;
    else           s = s;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    if (x >= y) d = {1'b0, x} - {1'b0, y};
    else        d = {1'b0, x} + Q_W1 - {1'b0, y};
    return d[W-1:0];
  endfunction

  // Barrett reduction with a constant multiplier: the quotient estimate is low by at most 2.
  function automatic logic [W-1:0] mod_reduce(input logic [2*W-1:0] p);
    logic [3*W:0]   prod;
    logic [W-1:0]   qe;
    logic [2*W-1:0] r;
    prod = {{(W+1){1'b0}}, p} * BAR_M;
    qe   = prod[3*W-1:2*W];
    r    = p - ({{W{1'b0}}, qe} * Q_W2);
    if (r >= Q_W2) r = r - Q_W2;
    else           r = r;
    if (r >= Q_W2) r = r - Q_W2;
    else           r = r;
    return r[W-1:0];
  endfunction

  logic           stall_s;
  logic [W-1:0]   x_s;

  logic           v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, ov_q, ov_d;
  logic [W-1:0]   a1_q, a1_d, b1_q, b1_d;
  logic [2*W-1:0] p2_q, p2_d;
  logic [W-1:0]   a2_q, a2_d, a3_q, a3_d, t3_q, t3_d;
  logic [W-1:0]   oa_q, oa_d, ob_q, ob_d;
`ifdef KYBER_BF_INTT_EN
  logic           inv1_q, inv1_d, inv2_q, inv2_d, inv3_q, inv3_d;
  logic [W-1:0]   sum2_q, sum2_d, sum3_q, sum3_d;
`else
  logic           unused_inv_s;
  assign unused_inv_s = in_inv;
`endif

  assign stall_s   = ov_q & ~out_ready;
  assign in_ready  = ~stall_s;
  assign zeta_ad   = in_k;
  assign zeta_ce   = ~stall_s;
  assign out_valid = ov_q;
  assign out_a     = oa_q;
  assign out_b     = ob_q;

  // Next-state for every pipeline stage; zeta_dout belongs to the request held in S1.
  always_comb begin
    a1_d = in_a;
    b1_d = in_b;
    v1_d = in_valid;
`ifdef KYBER_BF_INTT_EN
    inv1_d = in_inv;
    if (inv1_q) x_s = mod_sub(b1_q, a1_q);
    else        x_s = b1_q;
    inv2_d = inv1_q;
    sum2_d = mod_add(a1_q, b1_q);
    inv3_d = inv2_q;
    sum3_d = sum2_q;
`else
    x_s = b1_q;
`endif
    p2_d = {{W{1'b0}}, zeta_dout} * {{W{1'b0}}, x_s};
    a2_d = a1_q;
    v2_d = v1_q;
    t3_d = mod_reduce(p2_q);
    a3_d = a2_q;
    v3_d = v2_q;
    ov_d = v3_q;
`ifdef KYBER_BF_INTT_EN
    if (inv3_q) begin
      oa_d = sum3_q;
      ob_d = t3_q;
    end else begin
      oa_d = mod_add(a3_q, t3_q);
      ob_d = mod_sub(a3_q, t3_q);
    end
`else
    oa_d = mod_add(a3_q, t3_q);
    ob_d = mod_sub(a3_q, t3_q);
`endif
  end

  // Pipeline and output registers: all advance together, all hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;  v2_q <= 1'b0;  v3_q <= 1'b0;  ov_q <= 1'b0;
      a1_q <= {W{1'b0}};  b1_q <= {W{1'b0}};
      p2_q <= {(2*W){1'b0}};  a2_q <= {W{1'b0}};
      t3_q <= {W{1'b0}};  a3_q <= {W{1'b0}};
      oa_q <= {W{1'b0}};  ob_q <= {W{1'b0}};
`ifdef KYBER_BF_INTT_EN
      inv1_q <= 1'b0;  inv2_q <= 1'b0;  inv3_q <= 1'b0;
      sum2_q <= {W{1'b0}};  sum3_q <= {W{1'b0}};
`endif
    end else if (!stall_s) begin
      v1_q <= v1_d;  v2_q <= v2_d;  v3_q <= v3_d;  ov_q <= ov_d;
      a1_q <= a1_d;  b1_q <= b1_d;
      p2_q <= p2_d;  a2_q <= a2_d;
      t3_q <= t3_d;  a3_q <= a3_d;
      oa_q <= oa_d;  ob_q <= ob_d;
`ifdef KYBER_BF_INTT_EN
      inv1_q <= inv1_d;  inv2_q <= inv2_d;  inv3_q <= inv3_d;
      sum2_q <= sum2_d;  sum3_q <= sum3_d;
`endif
    end
  end

endmodule
